// File: rtl/pkt_pkg.sv
// Shared framing constants and parser state encoding for the packet ingress/egress path.
// Used by both the input parser and the per-port output framer.
package pkt_pkg;

  localparam logic [7:0] SOF_BYTE  = 8'hFF;
  localparam logic [7:0] DELIMITER = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

endpackage

// File: rtl/pkt_addr_match.sv
// Destination lookup: compares a byte against every port address, lowest index wins.
// Purely combinational; no backpressure.
module pkt_addr_match #(
  parameter int W_WIDTH = 8,
  parameter int N_PORTS = 4
) (
  input  logic [W_WIDTH-1:0]         data,
  input  logic [N_PORTS*W_WIDTH-1:0] addr_cfg,
  output logic                       hit,
  output logic [$clog2(N_PORTS)-1:0] idx
);

  localparam int IDX_W = $clog2(N_PORTS);

  // Scan high-to-low so the last assignment is the lowest matching port.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (addr_cfg[i*W_WIDTH +: W_WIDTH] == data) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/pkt_rx_parser.sv
// Splits the framed serial stream (SOF, addr, payload, 0x00) into per-port FIFO writes.
// One-cycle write latency; no input backpressure, full destinations cause drops.
module pkt_rx_parser
  import pkt_pkg::*;
#(
  parameter int W_WIDTH = 8,
  parameter int N_PORTS = 4,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W_WIDTH-1:0]         data_in,
  input  logic                       data_valid,
  input  logic [N_PORTS*W_WIDTH-1:0] addr_cfg,
  input  logic [N_PORTS-1:0]         fifo_full,
  output logic [N_PORTS-1:0]         wr_en,
  output logic [W_WIDTH-1:0]         wr_data,
  output logic                       busy,
  output logic [CNT_W-1:0]           pkt_cnt,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       pkt_err
);

  localparam int               IDX_W   = $clog2(N_PORTS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state;
  logic [IDX_W-1:0]   sel;
  logic               match_hit;
  logic [IDX_W-1:0]   match_idx;
  logic               is_sof;
  logic               is_delim;

  assign is_sof   = (data_in == W_WIDTH'(SOF_BYTE));
  assign is_delim = (data_in == W_WIDTH'(DELIMITER));
  assign busy     = (state != IDLE);

  pkt_addr_match #(
    .W_WIDTH (W_WIDTH),
    .N_PORTS (N_PORTS)
  ) u_addr_match (
    .data     (data_in),
    .addr_cfg (addr_cfg),
    .hit      (match_hit),
    .idx      (match_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= '0;
      wr_en    <= '0;
      wr_data  <= '0;
      pkt_cnt  <= '0;
      drop_cnt <= '0;
      pkt_err  <= 1'b0;
    end else begin
      wr_en   <= '0;
      pkt_err <= 1'b0;
      if (data_valid) begin
        case (state)
          IDLE: begin
            if (is_sof) state <= ADDR;
          end
          ADDR: begin
            sel <= match_idx;
            if (!match_hit || fifo_full[match_idx]) begin
              state <= DROP;
              if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
            end else begin
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            // fifo_full is almost-full: a byte seen while it is high must not be written.
            if (fifo_full[sel]) begin
              pkt_err <= 1'b1;
              if (drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
              state <= is_delim ? IDLE : DROP;
            end else begin
              wr_en   <= N_PORTS'(1) << sel;
              wr_data <= data_in;
              if (is_delim) begin
                if (pkt_cnt != CNT_MAX) pkt_cnt <= pkt_cnt + 1'b1;
                state <= IDLE;
              end
            end
          end
          DROP: begin
            if (is_delim) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pkt_rx_parser.sv
// Bench for pkt_rx_parser: packet-level reference model, per-cycle output compare.
module tb_pkt_rx_parser;

  localparam int NP   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int NEVER = 99;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          data_valid = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic [31:0]   addr_cfg = 32'h0;
  logic [3:0]    fifo_full = 4'h0;
  logic [3:0]    wr_en;
  logic [7:0]    wr_data;
  logic          busy;
  logic          pkt_err;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  pkt_rx_parser #(
    .W_WIDTH (8),
    .N_PORTS (NP),
    .CNT_W   (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .addr_cfg   (addr_cfg),
    .fifo_full  (fifo_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt),
    .pkt_err    (pkt_err)
  );

  typedef struct packed {
    logic [3:0]    we;
    logic [7:0]    d;
    logic          err;
    logic          bsy;
    logic [CW-1:0] pc;
    logic [CW-1:0] dc;
  } exp_t;

  exp_t       exp_a[int];
  exp_t       ce;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         err_pulses = 0;
  logic [7:0] cfg[NP];
  logic [7:0] pl[$];
  logic [7:0] got[NP][$];
  int         m_pkt = 0;
  int         m_drop = 0;
  bit         m_busy = 0;
  int         gap_pct = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every driven cycle has an expectation keyed by the output cycle.
  always @(negedge clk) begin
    if (exp_a.exists(cyc)) begin
      if (rst_n) begin
        ce = exp_a[cyc];
        chk("wr_en", 32'(wr_en), 32'(ce.we));
        if (ce.we != 4'b0) chk("wr_data", 32'(wr_data), 32'(ce.d));
        chk("pkt_err", 32'(pkt_err), 32'(ce.err));
        chk("busy", 32'(busy), 32'(ce.bsy));
        chk("pkt_cnt", 32'(pkt_cnt), 32'(ce.pc));
        chk("drop_cnt", 32'(drop_cnt), 32'(ce.dc));
      end
      exp_a.delete(cyc);
    end
    if (rst_n) begin
      for (int p = 0; p < NP; p++)
        if (wr_en[p] === 1'b1) got[p].push_back(wr_data);
      if (pkt_err === 1'b1) err_pulses++;
    end
  end

  function automatic int sat(input int x);
    return (x < CMAX) ? x + 1 : x;
  endfunction

  function automatic int dest_of(input logic [7:0] a);
    for (int i = 0; i < NP; i++)
      if (cfg[i] == a) return i;
    return -1;
  endfunction

  // One clock of stimulus; model state (m_*) must already reflect this byte.
  task automatic step(input bit v, input logic [7:0] b, input logic [3:0] full,
                      input int port, input bit err);
    exp_t e;
    @(posedge clk);
    #1;
    data_valid = v;
    data_in    = b;
    fifo_full  = full;
    e.we  = (port >= 0) ? 4'(1 << port) : 4'b0;
    e.d   = b;
    e.err = err;
    e.bsy = m_busy;
    e.pc  = CW'(m_pkt);
    e.dc  = CW'(m_drop);
    exp_a[cyc + 1] = e;
  endtask

  task automatic gaps();
    while ($urandom_range(99) < gap_pct)
      step(1'b0, 8'($urandom), 4'($urandom), -1, 1'b0);
  endtask

  task automatic flush(input int n);
    repeat (n) step(1'b0, 8'h00, 4'h0, -1, 1'b0);
  endtask

  // k: stream index (0=address, 1..L payload, L+1 delimiter) from which the
  // destination reports full; k > L+1 means it never does.
  task automatic send_pkt(input logic [7:0] addr, input int k);
    int         p;
    int         len;
    int         wport;
    bit         routed;
    bit         err;
    logic [3:0] r;
    logic [7:0] b;
    p      = dest_of(addr);
    len    = pl.size();
    routed = (p >= 0) && (k > 0);
    gaps();
    m_busy = 1;
    step(1'b1, 8'hFF, 4'($urandom), -1, 1'b0);
    gaps();
    r = 4'($urandom);
    if (p >= 0) r[p] = (k == 0);
    if (!routed) m_drop = sat(m_drop);
    step(1'b1, addr, r, -1, 1'b0);
    for (int j = 1; j <= len + 1; j++) begin
      gaps();
      b = (j <= len) ? pl[j-1] : 8'h00;
      r = 4'($urandom);
      if (p >= 0) r[p] = (j >= k);
      wport = -1;
      err   = 1'b0;
      if (routed && j < k) begin
        wport = p;
        if (j == len + 1) m_pkt = sat(m_pkt);
      end else if (routed && j == k) begin
        err    = 1'b1;
        m_drop = sat(m_drop);
      end
      if (j == len + 1) m_busy = 0;
      step(1'b1, b, r, wport, err);
    end
  endtask

  // Asserted between clock edges so a byte driven just before it is never written.
  task automatic do_reset();
    #2;
    rst_n      = 1'b0;
    data_valid = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_pkt_err", 32'(pkt_err), 32'h0);
    m_pkt  = 0;
    m_drop = 0;
    m_busy = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic clear_got();
    for (int p = 0; p < NP; p++) got[p].delete();
    err_pulses = 0;
  endtask

  task automatic set_cfg(input logic [7:0] a0, input logic [7:0] a1,
                         input logic [7:0] a2, input logic [7:0] a3);
    cfg[0] = a0; cfg[1] = a1; cfg[2] = a2; cfg[3] = a3;
    addr_cfg = {a3, a2, a1, a0};
  endtask

  task automatic check_port(input string name, input int p, input int n, input logic [31:0] exp);
    logic [31:0] act;
    act = 32'h0;
    chk({name, "_len"}, 32'(got[p].size()), 32'(n));
    for (int i = 0; i < got[p].size(); i++) act = {act[23:0], got[p][i]};
    chk(name, act, exp);
  endtask

  initial begin
    set_cfg(8'h10, 8'h20, 8'h30, 8'h40);

    // Basic routing to port 1.
    do_reset(); clear_got(); gap_pct = 0;
    pl = '{8'h11, 8'h22};
    send_pkt(8'h20, NEVER);
    flush(2);
    check_port("s1_port1", 1, 3, 32'h00112200);
    chk("s1_others", 32'(got[0].size() + got[2].size() + got[3].size()), 32'd0);
    chk("s1_pkt_cnt", 32'(pkt_cnt), 32'd1);
    chk("s1_drop_cnt", 32'(drop_cnt), 32'd0);

    // Unknown address with gaps, then 0xFF as payload data.
    do_reset(); clear_got(); gap_pct = 50;
    pl = '{8'hAA};
    send_pkt(8'h55, NEVER);
    pl = '{8'hFF};
    send_pkt(8'h10, NEVER);
    flush(2);
    check_port("s2_port0", 0, 2, 32'h0000FF00);
    chk("s2_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("s2_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Destination full at the address byte.
    do_reset(); clear_got(); gap_pct = 0;
    pl = '{8'h01};
    send_pkt(8'h30, 0);
    flush(2);
    chk("s3_port2_len", 32'(got[2].size()), 32'd0);
    chk("s3_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("s3_pkt_cnt", 32'(pkt_cnt), 32'd0);

    // Truncation: port 3 goes full on payload byte 02.
    do_reset(); clear_got();
    pl = '{8'h01, 8'h02, 8'h03};
    send_pkt(8'h40, 2);
    flush(2);
    check_port("s4_port3", 3, 1, 32'h00000001);
    chk("s4_err_pulses", 32'(err_pulses), 32'd1);
    chk("s4_drop_cnt", 32'(drop_cnt), 32'd1);

    // Back-to-back with an empty packet, then reset mid-packet.
    do_reset(); clear_got();
    pl.delete();
    send_pkt(8'h10, NEVER);
    pl = '{8'h07};
    send_pkt(8'h20, NEVER);
    flush(2);
    check_port("s5_port0", 0, 1, 32'h00000000);
    check_port("s5_port1", 1, 2, 32'h00000700);
    chk("s5_pkt_cnt", 32'(pkt_cnt), 32'd2);
    clear_got();
    m_busy = 1;
    step(1'b1, 8'hFF, 4'h0, -1, 1'b0);
    step(1'b1, 8'h10, 4'h0, -1, 1'b0);
    step(1'b1, 8'h05, 4'h0, 0, 1'b0);
    do_reset();
    pl = '{8'h09};
    send_pkt(8'h10, NEVER);
    flush(2);
    check_port("s5_after_rst", 0, 2, 32'h00000900);
    chk("s5_after_rst_pkt", 32'(pkt_cnt), 32'd1);

    // Randomized batches; odd batches use duplicate and 0xFF/0x00 addresses.
    gap_pct = 25;
    for (int batch = 0; batch < 8; batch++) begin
      do_reset();
      if (batch % 2 == 0) set_cfg(8'h10, 8'h20, 8'h30, 8'h40);
      else                set_cfg(8'h10, 8'hFF, 8'h10, 8'h00);
      for (int n = 0; n < 40; n++) begin
        int         len;
        int         k;
        logic [7:0] a;
        if ($urandom_range(3) == 0)
          repeat ($urandom_range(1, 3))
            step(1'b1, 8'($urandom_range(0, 254)), 4'($urandom), -1, 1'b0);
        len = $urandom_range(0, 6);
        pl.delete();
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom_range(1, 255)));
        a = ($urandom_range(3) != 0) ? cfg[$urandom_range(0, NP-1)] : 8'($urandom);
        k = ($urandom_range(1) == 0) ? NEVER : $urandom_range(0, len + 1);
        send_pkt(a, k);
      end
      flush(2);
    end

    flush(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_rx_parser.md
Name: pkt_rx_parser

Overview:
- Ingress counterpart of the per-port output framer: accepts the serial framed byte stream and demultiplexes it into per-port packet FIFOs.
- Stream format: SOF byte 0xFF, destination address byte, payload bytes, delimiter 0x00.
- Strips SOF and address, writes payload plus the terminating 0x00 into the FIFO of the matching port. The output framer later re-frames FIFO contents up to and including the 0x00.
- Drops unaddressed packets, and packets whose destination is full, and counts them.

Parameters:
W_WIDTH, 8, byte width of stream and FIFO data
N_PORTS, 4, number of destination ports/FIFOs
CNT_W, 16, width of statistics counters

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
data_in  input  W_WIDTH  incoming stream byte
data_valid  input  1  data_in valid this cycle; no backpressure, every valid byte must be consumed
addr_cfg  input  N_PORTS*W_WIDTH  port i address in bits [i*W_WIDTH +: W_WIDTH]; static while not idle
fifo_full  input  N_PORTS  bit i high = FIFO i cannot accept a write issued next cycle (wire to almost-full, threshold 1)
wr_en  output  N_PORTS  one-hot FIFO write strobe, registered
wr_data  output  W_WIDTH  FIFO write data, registered
busy  output  1  high while state != IDLE
pkt_cnt  output  CNT_W  packets fully written (delimiter written), saturating
drop_cnt  output  CNT_W  packets dropped or truncated, saturating
pkt_err  output  1  one-cycle pulse on mid-packet overflow (truncation)

Behaviour:
- Reset: state IDLE, wr_en=0, wr_data=0, pkt_cnt=0, drop_cnt=0, pkt_err=0, sel=0. Reset mid-packet abandons the packet; no write is issued.
- Only cycles with data_valid=1 advance the FSM. Invalid cycles hold state and force wr_en=0.
- Latency: a payload byte accepted in cycle t appears on wr_data with wr_en[sel]=1 in cycle t+1.
- IDLE:
  - valid byte 0xFF -> ADDR.
  - any other byte is ignored and stays in IDLE (no count).
- ADDR (next valid byte):
  - Compare against every addr_cfg entry; lowest matching index wins and is latched into sel.
  - No match -> DROP, drop_cnt+1.
  - Match with fifo_full[sel]=1 -> DROP, drop_cnt+1.
  - Otherwise -> PAYLOAD.
  - Address bytes 0xFF and 0x00 are legal address values in this state.
- PAYLOAD (each valid byte), in priority order:
  - fifo_full[sel]=1: byte discarded, no write, pkt_err pulse, drop_cnt+1. Byte==0x00 -> IDLE, else -> DROP.
  - byte==0x00: write it, pkt_cnt+1, -> IDLE.
  - otherwise: write byte, stay in PAYLOAD. 0xFF is ordinary data here.
- DROP: consume valid bytes without writing; byte==0x00 -> IDLE.
- Empty packet (SOF, addr, 0x00) writes a single 0x00 and counts in pkt_cnt.
- Back-to-back packets: SOF may arrive in the cycle immediately after the delimiter. There is no idle gap requirement.
- Counters saturate at 2^CNT_W-1 and never wrap.
- pkt_cnt and drop_cnt never increment in the same cycle.
- fifo_full is sampled combinationally in the byte's cycle; the registered write lands the next cycle, hence the almost-full requirement.

Decomposition:
- Shared package pkt_pkg: SOF_BYTE=8'hFF, DELIMITER=8'h00, state encoding IDLE/ADDR/PAYLOAD/DROP. Shared with the output framer.
- One sub-module pkt_addr_match: combinational N_PORTS comparator plus lowest-index priority encoder. Outputs hit and idx[$clog2(N_PORTS)-1:0].

Test Plan:
- Setup for all scenarios: addr_cfg port0..3 = 0x10,0x20,0x30,0x40.
- Basic routing: FF 20 11 22 00 with data_valid continuous -> wr_en=0010 writes 11,22,00 each one cycle after input; pkt_cnt=1, drop_cnt=0.
- Unknown address plus gaps: FF 55 AA 00, data_valid toggling -> no wr_en, drop_cnt=1, busy low after 00. Then FF 10 FF 00 -> port0 receives FF,00.
- Destination full: fifo_full[2]=1, FF 30 01 00 -> DROP, no writes, drop_cnt=1.
- Truncation: FF 40 01 02 03 00 with fifo_full[3] rising on byte 02 -> port3 gets only 01, pkt_err pulses once, drop_cnt=1; trailing 03,00 consumed silently.
- Back-to-back, empty packet, and reset: FF 10 00 FF 20 07 00 with no gaps -> port0 gets 00, port1 gets 07,00, pkt_cnt=2. Then FF 10 05 with rst_n pulsed low -> all outputs zero immediately; a following FF 10 09 00 routes 09,00 to port0 normally.
